// File: rtl/oka_clmul_seq.sv
// Sequential carry-less multiplier: one H x H core reused for the three Karatsuba
// half products, then recombined and optionally reduced mod x^WIDTH + POLY.
module oka_clmul_seq #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h100B)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-2:0] y
);
  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * H - 1;
  localparam int YW = 2 * WIDTH - 1;

  typedef enum logic [2:0] {IDLE, MUL_LO, MUL_MID, MUL_HI, COMB, DONE} state_t;

  state_t         state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic           mode_q;
  logic [PW-1:0]  z0, z1, z2, mid, core_p;
  logic [H-1:0]   op_x, op_y;
  logic [YW-1:0]  p;

  function automatic logic [PW-1:0] clmul_h(input logic [H-1:0] xa, input logic [H-1:0] xb);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < H; i++)
      if (xb[i]) r ^= PW'(xa) << i;
    return r;
  endfunction

  // Top-down fold of every bit at or above x^WIDTH into the low half.
  function automatic logic [YW-1:0] reduce(input logic [YW-1:0] pin);
    logic [YW-1:0] r;
    r = pin;
    for (int i = YW - 1; i >= WIDTH; i--)
      if (r[i]) r ^= YW'({1'b1, POLY}) << (i - WIDTH);
    return YW'(r[WIDTH-1:0]);
  endfunction

  always_comb begin
    op_x = a_q[H-1:0];
    op_y = b_q[H-1:0];
    case (state)
      MUL_MID: begin
        op_x = a_q[H-1:0] ^ a_q[WIDTH-1:H];
        op_y = b_q[H-1:0] ^ b_q[WIDTH-1:H];
      end
      MUL_HI: begin
        op_x = a_q[WIDTH-1:H];
        op_y = b_q[WIDTH-1:H];
      end
      default: ;
    endcase
  end

  assign core_p   = clmul_h(op_x, op_y);
  assign mid      = z1 ^ z0 ^ z2;
  assign p        = YW'(z0) ^ (YW'(mid) << H) ^ (YW'(z2) << WIDTH);
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = MUL_LO;
      MUL_LO:  state_nx = MUL_MID;
      MUL_MID: state_nx = MUL_HI;
      MUL_HI:  state_nx = COMB;
      COMB:    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      z0        <= '0;
      z1        <= '0;
      z2        <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q    <= a;
          b_q    <= b;
          mode_q <= mode;
        end
        MUL_LO:  z0 <= core_p;
        MUL_MID: z1 <= core_p;
        MUL_HI:  z2 <= core_p;
        COMB: begin
          y         <= mode_q ? reduce(p) : p;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_oka_clmul_seq.sv
// Bench for oka_clmul_seq: WIDTH=16 and WIDTH=8 instances run in lockstep on shared
// handshake signals; results checked against constants and a polynomial-arithmetic model.
module tb_oka_clmul_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        mode = 1'b0;
  logic        in_ready16, in_ready8, out_valid16, out_valid8;
  logic [30:0] y16;
  logic [14:0] y8;
  int          checks = 0, failures = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  oka_clmul_seq #(.WIDTH(16), .POLY(16'h100B)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid16), .out_ready(out_ready), .y(y16));

  oka_clmul_seq #(.WIDTH(8), .POLY(8'h1B)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a[7:0]), .b(b[7:0]), .mode(mode), .out_valid(out_valid8), .out_ready(out_ready), .y(y8));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Polynomial product by shift-XOR; modular product by Horner doubling (xtime).
  function automatic logic [63:0] ref_model(input logic [31:0] ia, input logic [31:0] ib,
                                            input logic m, input int w, input logic [31:0] poly);
    logic [63:0] av, bv, r;
    av = 64'(ia) & ((64'd1 << w) - 1);
    bv = 64'(ib) & ((64'd1 << w) - 1);
    r  = '0;
    if (!m) begin
      for (int i = 0; i < w; i++) if (bv[i]) r ^= av << i;
    end else begin
      for (int i = w - 1; i >= 0; i--) begin
        r = r << 1;
        if (r[w]) r ^= (64'd1 << w) | 64'(poly);
        if (bv[i]) r ^= av;
      end
    end
    return r;
  endfunction

  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic im,
                        input int gap, input int hold, input logic [63:0] exp16);
    logic [63:0] exp8;
    int n, lat;
    exp8 = ref_model(32'(ia), 32'(ib), im, 8, 32'h1B);
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (gap) @(negedge clk);
    n = 0;
    while (!in_ready16 && n < 20) begin @(negedge clk); n++; end
    chk("idle_wait", 64'(in_ready16), 64'd1);
    if (!in_ready16) return;
    a = ia; b = ib; mode = im; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom);
    chk("busy_ready", 64'({in_ready16, in_ready8}), 64'd0);
    lat = 0;
    while (!out_valid16 && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    chk("latency", 64'(lat), 64'd4);
    chk("valid8", 64'(out_valid8), 64'd1);
    chk("y16", 64'(y16), exp16);
    chk("y8", 64'(y8), exp8);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_y16", 64'(y16), exp16);
      chk("hold_y8", 64'(y8), exp8);
      chk("hold_hs", 64'({out_valid16, out_valid8, in_ready16, in_ready8}), 64'b1100);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("release", 64'({out_valid16, out_valid8, in_ready16, in_ready8}), 64'b0011);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        m;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int acc_t[$];
    int n;
    bit seen;
    logic [15:0] ra, rb;
    logic        rm;

    tbl[0] = '{16'h0003, 16'h0003, 1'b0, 32'h0000_0005};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'h5555_5555};
    tbl[2] = '{16'h8000, 16'h8000, 1'b0, 32'h4000_0000};
    tbl[3] = '{16'h8000, 16'h0002, 1'b1, 32'h0000_100B};
    tbl[4] = '{16'h8000, 16'h0002, 1'b0, 32'h0001_0000};
    tbl[5] = '{16'h0000, 16'hABCD, 1'b1, 32'h0000_0000};
    tbl[6] = '{16'hABCD, 16'h0000, 1'b0, 32'h0000_0000};
    tbl[7] = '{16'h1234, 16'h0001, 1'b0, 32'h0000_1234};

    #1;
    chk("rst_state16", 64'({in_ready16, out_valid16, y16}), 64'({1'b1, 1'b0, 31'd0}));
    chk("rst_state8", 64'({in_ready8, out_valid8, y8}), 64'({1'b1, 1'b0, 15'd0}));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].m, 1, 0, 64'(tbl[i].exp));

    // Backpressure: result must sit unchanged for 10 cycles.
    run_op(16'h0003, 16'h0003, 1'b0, 0, 10, 64'h5);

    // Back-to-back with out_ready high: accepts exactly 6 edges apart.
    out_ready = 1'b1;
    a = 16'h0003; b = 16'h0005; mode = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (in_ready16 && in_valid) acc_t.push_back(cyc + 1);
      if (out_valid16) begin
        chk("done_ready", 64'(in_ready16), 64'd0);
        chk("tp_y16", 64'(y16), 64'hF);
      end
      @(negedge clk);
    end
    chk("tp_accepts", 64'(acc_t.size()), 64'd3);
    if (acc_t.size() >= 3) begin
      chk("tp_period1", 64'(acc_t[1] - acc_t[0]), 64'd6);
      chk("tp_period2", 64'(acc_t[2] - acc_t[1]), 64'd6);
    end
    in_valid = 1'b0;
    n = 0;
    while (!(in_ready16 && !out_valid16) && n < 20) begin @(negedge clk); n++; end
    chk("tp_drain", 64'(in_ready16), 64'd1);
    out_ready = 1'b0;

    // Reset during MUL_MID discards the operation.
    a = 16'h00FF; b = 16'h0101; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst16", 64'({in_ready16, out_valid16, y16}), 64'({1'b1, 1'b0, 31'd0}));
    chk("midrst8", 64'({in_ready8, out_valid8, y8}), 64'({1'b1, 1'b0, 15'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (out_valid16 || out_valid8) seen = 1'b1; end
    chk("no_stale_valid", 64'(seen), 64'd0);
    run_op(16'h1234, 16'h0001, 1'b0, 0, 0, 64'h1234);

    // Random operands, gaps and backpressure.
    for (int i = 0; i < 3000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rm = 1'($urandom);
      case ($urandom_range(0, 9))
        0: ra = '0;
        1: rb = '0;
        2: ra = 16'hFFFF;
        3: rb = 16'h8000;
        default: ;
      endcase
      run_op(ra, rb, rm, $urandom_range(0, 2), $urandom_range(0, 2),
             ref_model(32'(ra), 32'(rb), rm, 16, 32'h100B));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
